// File: rtl/jtkunio_gfx_pkg.sv
// Shared definitions for the tile-layer ROM fetch slot: state encoding,
// default SDRAM address width and burst length.
package jtkunio_gfx_pkg;

  localparam int SDRAM_AW_DEF = 22;
  localparam int BURST_LEN    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } slot_state_t;

endpackage

// File: rtl/jtkunio_gfx_slot_if.sv
// Layer-side ROM port plus arbiter-side SDRAM burst port of one graphics slot.
interface jtkunio_gfx_slot_if #(
  parameter int AW       = 14,
  parameter int SDRAM_AW = 22
);

  logic                rom_cs;
  logic [AW-1:0]       rom_addr;
  logic [31:0]         rom_data;
  logic                rom_ok;
  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                sdram_dok;
  logic [15:0]         sdram_din;

  // master is the surrounding environment (layer + arbiter), slave is the slot
  modport master (
    output rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_din,
    input  rom_data, rom_ok, sdram_req, sdram_addr
  );

  modport slave (
    input  rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_din,
    output rom_data, rom_ok, sdram_req, sdram_addr
  );

endinterface

// File: rtl/jtkunio_gfx_slot.sv
// One-entry tag cache between a tile layer and the SDRAM arbiter; a miss
// triggers a two-word burst that is assembled into one 32-bit ROM word.
module jtkunio_gfx_slot
  import jtkunio_gfx_pkg::*;
#(
  parameter int                  AW       = 14,
  parameter int                  SDRAM_AW = SDRAM_AW_DEF,
  parameter logic [SDRAM_AW-1:0] OFFSET   = '0
)(
  input logic               clk,
  input logic               rst,
  jtkunio_gfx_slot_if.slave bus
);

  slot_state_t         r_state;
  slot_state_t         w_nextState;
  logic [AW-2:0]       r_tag;
  logic                r_valid;
  logic [31:0]         r_data;
  logic [15:0]         r_loTmp;
  logic                r_req;
  logic [SDRAM_AW-1:0] r_addr;

  logic                w_hit;
  logic                w_miss;
  logic [SDRAM_AW-1:0] w_lineAddr;
  logic                w_unusedAddrLsb;

  // Requests are 32-bit aligned, so the word-select bit never matters.
  assign w_unusedAddrLsb = bus.rom_addr[0];

  assign w_hit      = r_valid && (r_tag == bus.rom_addr[AW-1:1]);
  assign w_miss     = bus.rom_cs && !w_hit;
  assign w_lineAddr = OFFSET + SDRAM_AW'({bus.rom_addr[AW-1:1], 1'b0});

  assign bus.rom_ok     = bus.rom_cs && w_hit;
  assign bus.rom_data   = r_data;
  assign bus.sdram_req  = r_req;
  assign bus.sdram_addr = r_addr;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_miss)        w_nextState = REQ;
      REQ:     if (bus.sdram_ack) w_nextState = WAIT_LO;
      WAIT_LO: if (bus.sdram_dok) w_nextState = WAIT_HI;
      WAIT_HI: if (bus.sdram_dok) w_nextState = IDLE;
    endcase
  end

  // A burst always completes into the tag latched at its start, even if the
  // layer moves on; IDLE then re-checks the live address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tag   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_loTmp <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_tag   <= bus.rom_addr[AW-1:1];
            r_valid <= 1'b0;
            r_addr  <= w_lineAddr;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.sdram_ack) r_req <= 1'b0;
        end
        WAIT_LO: begin
          if (bus.sdram_dok) r_loTmp <= bus.sdram_din;
        end
        WAIT_HI: begin
          if (bus.sdram_dok) begin
            r_data  <= {bus.sdram_din, r_loTmp};
            r_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
